ahb_apb_bridge: RTL and testbench

AHB-to-APB bridge: an AHB slave that sits downstream of the AHB master/arbiter fabric, beside the memory slave on the same HSEL/HTRANS/HADDR/HWDATA bus. It converts each accepted AHB single transfer into one APB SETUP/ACCESS transaction. It inserts wait states through HREADYOUT until the APB completer responds, then returns read data and the response on the AHB side.

---
 rtl/ahb_apb_pkg.sv | 22 ++
 rtl/ahb_apb_bridge_if.sv | 40 ++++
 rtl/apb_psel_decode.sv | 14 +
 rtl/ahb_apb_bridge.sv | 104 ++++++++++
 tb/tb_ahb_apb_bridge.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared encodings and state type for the AHB-to-APB bridge.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int N_COMPLETERS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } br_state_e;

endpackage

// File: rtl/ahb_apb_bridge_if.sv
// AHB slave-side and APB requester-side signal bundle of the bridge.
interface ahb_apb_bridge_if
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                    HSEL;
    logic                    HWRITE;
    logic [1:0]              HTRANS;
    logic [ADDR_W-1:0]       HADDR;
    logic [DATA_W-1:0]       HWDATA;
    logic                    HREADY;
    logic                    HREADYOUT;
    logic [DATA_W-1:0]       HRDATA;
    logic                    HRESP;
    logic [ADDR_W-1:0]       PADDR;
    logic                    PWRITE;
    logic [DATA_W-1:0]       PWDATA;
    logic [N_COMPLETERS-1:0] PSEL;
    logic                    PENABLE;
    logic [DATA_W-1:0]       PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport slave (
        input  HSEL, HWRITE, HTRANS, HADDR, HWDATA, HREADY,
        input  PRDATA, PREADY, PSLVERR,
        output HREADYOUT, HRDATA, HRESP,
        output PADDR, PWRITE, PWDATA, PSEL, PENABLE
    );

    modport master (
        output HSEL, HWRITE, HTRANS, HADDR, HWDATA, HREADY,
        output PRDATA, PREADY, PSLVERR,
        input  HREADYOUT, HRDATA, HRESP,
        input  PADDR, PWRITE, PWDATA, PSEL, PENABLE
    );

endinterface

// File: rtl/apb_psel_decode.sv
// Peripheral-select field to one-hot APB PSEL.
module apb_psel_decode
    import ahb_apb_pkg::*;
(
    input  logic [1:0]              sel,
    output logic [N_COMPLETERS-1:0] psel
);

    always_comb begin
        psel      = '0;
        psel[sel] = 1'b1;
    end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB single-transfer to APB SETUP/ACCESS bridge with wait-state insertion.
// Define AHB_APB_PSLVERR_EN to map PSLVERR onto a two-cycle AHB ERROR.
module ahb_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int PSEL_LSB = 12
)(
    input logic              HCLK,
    input logic              HRESET,
    ahb_apb_bridge_if.slave  bus
);

    br_state_e               state_q, state_d;
    logic [ADDR_W-1:0]       paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [N_COMPLETERS-1:0] psel_q, psel_d, psel_dec;
    logic [DATA_W-1:0]       hrdata_q, hrdata_d;
    logic                    accept, idle_like, load;
    logic                    unused_htrans0;

    apb_psel_decode u_psel_decode (
        .sel  (bus.HADDR[PSEL_LSB+1:PSEL_LSB]),
        .psel (psel_dec)
    );

    assign unused_htrans0 = bus.HTRANS[0];
    assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

`ifdef AHB_APB_PSLVERR_EN
    // ERR2 is the second ERROR cycle and also an AHB address-phase slot
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign bus.HRESP = (state_q == ST_ERR1 || state_q == ST_ERR2)
                     ? HRESP_ERROR : HRESP_OKAY;
`else
    logic unused_pslverr;
    assign unused_pslverr = bus.PSLVERR;
    assign idle_like = (state_q == ST_IDLE);
    assign bus.HRESP = HRESP_OKAY;
`endif

    assign load = accept & idle_like;

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        psel_d   = psel_q;
        hrdata_d = hrdata_q;
        if (load) begin
            paddr_d  = bus.HADDR;
            pwrite_d = bus.HWRITE;
            psel_d   = psel_dec;
        end
        unique case (state_q)
            ST_IDLE:   state_d = load ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (bus.PREADY) begin
                    psel_d = '0;
`ifdef AHB_APB_PSLVERR_EN
                    if (bus.PSLVERR) state_d = ST_ERR1;
                    else
`endif
                    begin
                        state_d = ST_IDLE;
                        if (!pwrite_q) hrdata_d = bus.PRDATA;
                    end
                end
            end
`ifdef AHB_APB_PSLVERR_EN
            ST_ERR1:   state_d = ST_ERR2;
            ST_ERR2:   state_d = load ? ST_SETUP : ST_IDLE;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            psel_q   <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            psel_q   <= psel_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign bus.HREADYOUT = idle_like;
    assign bus.HRDATA    = hrdata_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = bus.HWDATA;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = (state_q == ST_ACCESS);

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge against a transfer-level model.
module tb_ahb_apb_bridge;
    import ahb_apb_pkg::*;

`ifdef AHB_APB_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit hready_block = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hrdata = 32'h0;

    always #5 clk = ~clk;

    ahb_apb_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    assign bus.HREADY = bus.HREADYOUT & ~hready_block;

    ahb_apb_bridge #(.ADDR_W(32), .DATA_W(32), .PSEL_LSB(12)) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    // One AHB single transfer; the APB completer holds PREADY low for nwait
    // ACCESS cycles. Expectations come from the transfer description only.
    task automatic do_xfer(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] prdata,
                           input int nwait, input logic err, input string tag);
        logic [3:0] exp_psel;
        logic [3:0] exp_ps;
        logic exp_en;
        bit err_hit, done;
        int exp_waits, waits, acc, hresp_n;
        err_hit   = err && ERR_EN;
        exp_psel  = 4'b0001 << addr[13:12];
        exp_waits = 2 + nwait + (err_hit ? 1 : 0);
        bus.HSEL    = 1'b1;
        bus.HTRANS  = ($urandom_range(1) == 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
        bus.HWRITE  = wr;
        bus.HADDR   = addr;
        bus.HWDATA  = $urandom;
        bus.PRDATA  = prdata;
        bus.PSLVERR = err;
        bus.PREADY  = 1'b0;
        @(posedge clk); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HADDR  = $urandom;
        bus.HWRITE = 1'($urandom);
        bus.HWDATA = wdata;
        waits = 0; acc = 0; hresp_n = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (bus.PENABLE) acc++;
            bus.PREADY = bus.PENABLE && (acc > nwait);
            @(negedge clk);
            exp_ps = (c <= nwait + 1) ? exp_psel : 4'b0;
            exp_en = (c >= 1 && c <= nwait + 1);
            checks++;
            if (bus.PSEL !== exp_ps || bus.PENABLE !== exp_en) begin
                errors++;
                $display("FAIL %s.apb c=%0d psel=%b en=%b exp psel=%b en=%b",
                         tag, c, bus.PSEL, bus.PENABLE, exp_ps, exp_en);
            end
            if (exp_ps != 4'b0) begin
                checks++;
                if (bus.PADDR !== addr || bus.PWRITE !== wr ||
                    (wr && bus.PWDATA !== wdata)) begin
                    errors++;
                    $display("FAIL %s.addr got=%h/%b/%h exp=%h/%b/%h", tag,
                             bus.PADDR, bus.PWRITE, bus.PWDATA, addr, wr, wdata);
                end
            end
            if (bus.HRESP) hresp_n++;
            if (bus.HREADYOUT) done = 1;
            else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        checks++;
        if (!done || waits != exp_waits) begin
            errors++;
            $display("FAIL %s.waits got=%0d exp=%0d done=%0d", tag, waits, exp_waits, done);
        end
        checks++;
        if (bus.HRESP !== err_hit || hresp_n != (err_hit ? 2 : 0)) begin
            errors++;
            $display("FAIL %s.hresp got=%b n=%0d exp=%b n=%0d", tag,
                     bus.HRESP, hresp_n, err_hit, err_hit ? 2 : 0);
        end
        if (!wr && !err_hit) exp_hrdata = prdata;
        checks++;
        if (bus.HRDATA !== exp_hrdata) begin
            errors++;
            $display("FAIL %s.hrdata got=%h exp=%h", tag, bus.HRDATA, exp_hrdata);
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.HSEL   = 1'($urandom);
            bus.HTRANS = ($urandom_range(1) == 1) ? HTRANS_BUSY : HTRANS_IDLE;
            bus.HADDR  = $urandom;
            bus.HWRITE = 1'($urandom);
            @(negedge clk);
            checks++;
            if (bus.HREADYOUT !== 1'b1 || bus.PSEL !== 4'b0 || bus.HRESP !== 1'b0) begin
                errors++;
                $display("FAIL %s.idle rdy=%b psel=%b resp=%b exp 1/0000/0",
                         tag, bus.HREADYOUT, bus.PSEL, bus.HRESP);
            end
        end
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0 ||
            bus.PSEL !== 4'b0 || bus.PENABLE !== 1'b0) begin
            errors++;
            $display("FAIL %s rdy=%b resp=%b rdata=%h psel=%b en=%b exp 1/0/0/0000/0",
                     tag, bus.HREADYOUT, bus.HRESP, bus.HRDATA, bus.PSEL, bus.PENABLE);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        checks++;
        if (bus.PADDR !== 32'h0 || bus.PWRITE !== 1'b0) begin
            errors++;
            $display("FAIL reset.paddr got=%h/%b exp=0/0", bus.PADDR, bus.PWRITE);
        end
        exp_hrdata = 32'h0;
        rst = 1'b0;
    endtask

    task automatic test_write();
        do_xfer(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 32'h5555_AAAA, 0, 1'b0, "write");
        idle_cycles(2, "write");
    endtask

    task automatic test_read_wait();
        do_xfer(1'b0, 32'h0000_3010, 32'h0, 32'h1234_5678, 3, 1'b0, "read_wait");
        idle_cycles(2, "read_wait");
    endtask

    task automatic test_back_to_back();
        do_xfer(1'b1, 32'h0000_0000, 32'hA5A5_0001, 32'h0, 0, 1'b0, "b2b_w");
        do_xfer(1'b0, 32'h0000_1000, 32'h0, 32'hCAFE_F00D, 1, 1'b0, "b2b_r");
        do_xfer(1'b1, 32'h0000_2ABC, 32'h0BAD_0002, 32'h1, 2, 1'b0, "b2b_w2");
        idle_cycles(1, "b2b");
    endtask

    task automatic test_error();
        do_xfer(1'b0, 32'h0000_1234, 32'h0, 32'h7777_8888, 1, 1'b1, "err_r");
        do_xfer(1'b0, 32'h0000_3000, 32'h0, 32'h1111_2222, 0, 1'b0, "err_next");
        do_xfer(1'b1, 32'h0000_0040, 32'h3333_4444, 32'h0, 0, 1'b1, "err_w");
        idle_cycles(2, "err");
    endtask

    task automatic test_idle_busy();
        idle_cycles(6, "idle_busy");
    endtask

    task automatic test_hready_low();
        hready_block = 1'b1;
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HADDR  = 32'h0000_1008;
        bus.HWRITE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.PSEL !== 4'b0 || bus.PENABLE !== 1'b0 || bus.HREADYOUT !== 1'b1) begin
                errors++;
                $display("FAIL hready_low psel=%b en=%b rdy=%b exp 0000/0/1",
                         bus.PSEL, bus.PENABLE, bus.HREADYOUT);
            end
        end
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        hready_block = 1'b0;
        idle_cycles(1, "hready_low");
    endtask

    task automatic test_reset_mid();
        do_xfer(1'b0, 32'h0000_2020, 32'h0, 32'h9ABC_DEF0, 0, 1'b0, "pre_rst");
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 32'h0000_1100;
        bus.PREADY = 1'b0;
        @(posedge clk); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.PENABLE !== 1'b1 || bus.PSEL !== 4'b0010) begin
            errors++;
            $display("FAIL rst_mid.access en=%b psel=%b exp 1/0010", bus.PENABLE, bus.PSEL);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_vals("rst_mid");
        rst = 1'b0;
        exp_hrdata = 32'h0;
        idle_cycles(1, "rst_mid");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = {18'h0, 2'($urandom), 12'($urandom)};
            do_xfer(1'($urandom), a, $urandom, $urandom,
                    int'($urandom_range(3)), ($urandom_range(3) == 0), "rand");
            if ($urandom_range(1) == 1) idle_cycles(int'($urandom_range(1, 3)), "rand");
        end
        idle_cycles(1, "rand");
    endtask

    initial begin
        bus.HSEL    = 1'b0;
        bus.HWRITE  = 1'b0;
        bus.HTRANS  = HTRANS_IDLE;
        bus.HADDR   = '0;
        bus.HWDATA  = '0;
        bus.PRDATA  = '0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_error();
        test_idle_busy();
        test_hready_low();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
